// File: rtl/hvac_pkg.sv
// Shared encodings for the HVAC actuator sequencer and its fan stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hvac_pkg;

    // Sequencer states; the numeric values are visible on state_o.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PURGE = 2'd2
    } state_t;

    // Fan speed codes from the comparator; 2'b11 is treated as high.
    localparam logic [1:0] SPD_OFF  = 2'b00;
    localparam logic [1:0] SPD_LOW  = 2'b01;
    localparam logic [1:0] SPD_HIGH = 2'b10;

    // Latched element selection while running.
    localparam logic MODE_HEAT = 1'b0;
    localparam logic MODE_COOL = 1'b1;

endpackage

// File: rtl/hvac_fan_pwm.sv
// Fan drive: ramps the duty toward a target and turns it into a PWM waveform.
// Latency: duty moves on tick edges; fan_pwm is registered one clk behind the counter.
// Backpressure: none; target_duty is a level sampled every clk.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   tick         - timebase strobe; the ramp only moves on tick cycles
//   target_duty  - duty the ramp heads toward
//   fan_pwm      - registered PWM output, high while counter < duty
//   fan_duty     - current ramped duty
module hvac_fan_pwm #(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] target_duty,
    output logic                fan_pwm,
    output logic [PWM_BITS-1:0] fan_duty
);

    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                fan_pwm_q, fan_pwm_d;

    always_comb begin
        duty_d = duty_q;
        // Differences are taken in the direction that cannot underflow, so the
        // duty lands exactly on the target and never wraps.
        if (tick) begin
            if (target_duty > duty_q) begin
                duty_d = ((target_duty - duty_q) > STEP) ? (duty_q + STEP) : target_duty;
            end else if (target_duty < duty_q) begin
                duty_d = ((duty_q - target_duty) > STEP) ? (duty_q - STEP) : target_duty;
            end
        end

        // Free-running counter wraps naturally at 2^PWM_BITS.
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        fan_pwm_d = (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q    <= '0;
            pwm_cnt_q <= '0;
            fan_pwm_q <= 1'b0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
            fan_pwm_q <= fan_pwm_d;
        end
    end

    assign fan_pwm  = fan_pwm_q;
    assign fan_duty = duty_q;

endmodule

// File: rtl/hvac_actuator_seq.sv
// HVAC actuator sequencer: min on-time, fan purge, anti-short-cycle lockout.
// Latency: enables/state registered, one clk after a qualifying request.
// Backpressure: none; requests are levels, sampled every clk.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   tick                - timebase strobe for all tick counters and the fan ramp
//   heat_req, cool_req  - comparator requests (both high = conflict, ignored)
//   speed_req           - comparator fan speed code
//   heat_en, cool_en    - registered element enables, mutually exclusive
//   fan_pwm, fan_duty   - fan PWM drive and current ramped duty
//   state_o             - OFF=0, RUN=1, PURGE=2
//   fault               - sticky conflicting-request flag
module hvac_actuator_seq
    import hvac_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int DUTY_LOW      = 96,
    parameter int DUTY_HIGH     = 255,
    parameter int RAMP_STEP     = 16,
    parameter int MIN_ON_TICKS  = 10,
    parameter int PURGE_TICKS   = 4,
    parameter int MIN_OFF_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                heat_req,
    input  logic                cool_req,
    input  logic [1:0]          speed_req,
    output logic                heat_en,
    output logic                cool_en,
    output logic                fan_pwm,
    output logic [PWM_BITS-1:0] fan_duty,
    output logic [1:0]          state_o,
    output logic                fault
);

    if (MIN_ON_TICKS < 1 || MIN_ON_TICKS > 255) begin : g_bad_min_on
        $error("MIN_ON_TICKS must be 1..255");
    end
    if (PURGE_TICKS < 1 || PURGE_TICKS > 255) begin : g_bad_purge
        $error("PURGE_TICKS must be 1..255");
    end
    if (MIN_OFF_TICKS < 0 || MIN_OFF_TICKS > 255) begin : g_bad_min_off
        $error("MIN_OFF_TICKS must be 0..255");
    end

    localparam logic [7:0]          MIN_ON  = 8'(MIN_ON_TICKS);
    localparam logic [7:0]          PURGE_T = 8'(PURGE_TICKS);
    localparam logic [7:0]          MIN_OFF = 8'(MIN_OFF_TICKS);
    localparam logic [PWM_BITS-1:0] D_LOW   = PWM_BITS'(DUTY_LOW);
    localparam logic [PWM_BITS-1:0] D_HIGH  = PWM_BITS'(DUTY_HIGH);

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [1:0]          speed_q, speed_d;
    logic [7:0]          on_cnt_q, on_cnt_d;
    logic [7:0]          purge_cnt_q, purge_cnt_d;
    logic [7:0]          off_cnt_q, off_cnt_d;
    logic                fault_q, fault_d;
    logic                heat_en_q, heat_en_d;
    logic                cool_en_q, cool_en_d;

    logic                conflict;
    logic                req_any;
    logic                req_mode;
    logic [PWM_BITS-1:0] target_duty;

    // A conflicting pair counts as no request at all.
    assign conflict = heat_req & cool_req;
    assign req_any  = heat_req ^ cool_req;
    assign req_mode = cool_req ? MODE_COOL : MODE_HEAT;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        on_cnt_d    = on_cnt_q;
        purge_cnt_d = purge_cnt_q;
        off_cnt_d   = off_cnt_q;
        fault_d     = fault_q | conflict;

        case (state_q)
            ST_OFF: begin
                if (tick && off_cnt_q != 8'd0) begin
                    off_cnt_d = off_cnt_q - 8'd1;
                end
                // Lockout is judged on the pre-edge count, so a request waits
                // one more edge after the last lockout tick.
                if (req_any && off_cnt_q == 8'd0) begin
                    state_d  = ST_RUN;
                    mode_d   = req_mode;
                    on_cnt_d = 8'd0;
                end
            end
            ST_RUN: begin
                if (tick && on_cnt_q != MIN_ON) begin
                    on_cnt_d = on_cnt_q + 8'd1;
                end
                // Dropped or reversed requests are ignored until min on-time;
                // a reversal always goes through PURGE and the lockout.
                if (!(req_any && req_mode == mode_q) && on_cnt_q == MIN_ON) begin
                    state_d     = ST_PURGE;
                    purge_cnt_d = PURGE_T;
                    off_cnt_d   = MIN_OFF;
                end
            end
            ST_PURGE: begin
                if (tick) begin
                    if (off_cnt_q != 8'd0) begin
                        off_cnt_d = off_cnt_q - 8'd1;
                    end
                    purge_cnt_d = purge_cnt_q - 8'd1;
                    if (purge_cnt_q == 8'd1) begin
                        state_d = ST_OFF;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Speed is tracked only while running; elsewhere the target ignores it.
        speed_d = (state_d == ST_RUN) ? speed_req : speed_q;

        // Enables derive from the next state and mode, so they can never overlap.
        heat_en_d = (state_d == ST_RUN) && (mode_d == MODE_HEAT);
        cool_en_d = (state_d == ST_RUN) && (mode_d == MODE_COOL);

        case (state_q)
            ST_RUN:   target_duty = (speed_q == SPD_OFF || speed_q == SPD_LOW) ? D_LOW : D_HIGH;
            ST_PURGE: target_duty = D_LOW;
            default:  target_duty = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            mode_q      <= MODE_HEAT;
            speed_q     <= SPD_OFF;
            on_cnt_q    <= 8'd0;
            purge_cnt_q <= 8'd0;
            off_cnt_q   <= 8'd0;
            fault_q     <= 1'b0;
            heat_en_q   <= 1'b0;
            cool_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            on_cnt_q    <= on_cnt_d;
            purge_cnt_q <= purge_cnt_d;
            off_cnt_q   <= off_cnt_d;
            fault_q     <= fault_d;
            heat_en_q   <= heat_en_d;
            cool_en_q   <= cool_en_d;
        end
    end

    hvac_fan_pwm #(
        .PWM_BITS  (PWM_BITS),
        .RAMP_STEP (RAMP_STEP)
    ) u_fan (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .target_duty (target_duty),
        .fan_pwm     (fan_pwm),
        .fan_duty    (fan_duty)
    );

    assign heat_en = heat_en_q;
    assign cool_en = cool_en_q;
    assign state_o = state_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_hvac_actuator_seq.sv
// Bench for hvac_actuator_seq: vector table, corner sequences, random vs model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_hvac_actuator_seq;

    localparam int DLOW  = 96;
    localparam int DHIGH = 255;
    localparam int STEP  = 16;
    localparam int MON   = 10;
    localparam int PT    = 4;
    localparam int MOFF  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       heat_req = 1'b0;
    logic       cool_req = 1'b0;
    logic [1:0] speed_req = 2'b00;
    logic       heat_en, cool_en, fan_pwm, fault;
    logic [7:0] fan_duty;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    hvac_actuator_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .heat_req  (heat_req),
        .cool_req  (cool_req),
        .speed_req (speed_req),
        .heat_en   (heat_en),
        .cool_en   (cool_en),
        .fan_pwm   (fan_pwm),
        .fan_duty  (fan_duty),
        .state_o   (state_o),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // state: 0 off, 1 running, 2 purging; mode: 0 heat, 1 cool.
    int m_state, m_mode, m_spd, m_on, m_purge, m_lock, m_duty, m_cycle;
    bit m_fault, m_pwm;

    task automatic model_edge(input bit r, input bit t, input bit h, input bit c, input int s);
        int want;
        int target;
        int o_on;
        int o_lock;
        if (!r) begin
            m_state = 0; m_mode = 0; m_spd = 0; m_on = 0; m_purge = 0;
            m_lock = 0; m_duty = 0; m_cycle = 0; m_pwm = 0; m_fault = 0;
            return;
        end
        want = (h && !c) ? 0 : ((c && !h) ? 1 : -1);
        if (m_state == 0)      target = 0;
        else if (m_state == 2) target = DLOW;
        else                   target = (m_spd >= 2) ? DHIGH : DLOW;

        m_pwm   = (m_cycle < m_duty);
        m_cycle = (m_cycle + 1) % 256;

        if (t) begin
            if (m_duty < target)      m_duty = (m_duty + STEP > target) ? target : m_duty + STEP;
            else if (m_duty > target) m_duty = (m_duty - STEP < target) ? target : m_duty - STEP;
        end
        if (h && c) m_fault = 1;

        o_on   = m_on;
        o_lock = m_lock;
        case (m_state)
            0: begin
                if (t && o_lock > 0) m_lock = o_lock - 1;
                if (want >= 0 && o_lock == 0) begin
                    m_state = 1; m_mode = want; m_on = 0; m_spd = s;
                end
            end
            1: begin
                if (t && o_on < MON) m_on = o_on + 1;
                if (want != m_mode && o_on == MON) begin
                    m_state = 2; m_purge = PT; m_lock = MOFF;
                end else begin
                    m_spd = s;
                end
            end
            default: begin
                if (t) begin
                    if (o_lock > 0) m_lock = o_lock - 1;
                    m_purge = m_purge - 1;
                    if (m_purge == 0) m_state = 0;
                end
            end
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("heat_en",    32'(heat_en),  32'(m_state == 1 && m_mode == 0));
        chk("cool_en",    32'(cool_en),  32'(m_state == 1 && m_mode == 1));
        chk("fan_pwm",    32'(fan_pwm),  32'(m_pwm));
        chk("fan_duty",   32'(fan_duty), 32'(m_duty));
        chk("state_o",    32'(state_o),  32'(m_state));
        chk("fault",      32'(fault),    32'(m_fault));
        chk("no_overlap", 32'(heat_en & cool_en), 32'd0);
    endtask

    task automatic step(input bit r, input bit t, input bit h, input bit c, input logic [1:0] s);
        rst_n     = r;
        tick      = t;
        heat_req  = h;
        cool_req  = c;
        speed_req = s;
        @(posedge clk);
        model_edge(r, t, h, c, int'(s));
        #1;
        check_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         n_clk;
        bit         tck;
        bit         h;
        bit         c;
        logic [1:0] s;
        int         e_state;
        bit         e_heat;
        bit         e_cool;
        int         e_duty;
    } vec_t;

    function automatic vec_t mk(int n, bit t, bit h, bit c, logic [1:0] s,
                                int es, bit eh, bit ec, int ed);
        vec_t v;
        v.n_clk = n; v.tck = t; v.h = h; v.c = c; v.s = s;
        v.e_state = es; v.e_heat = eh; v.e_cool = ec; v.e_duty = ed;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin : main
        int ticks;
        int cnt;
        bit t;
        bit r;
        bit h;
        bit c;
        logic [1:0] s;

        // Heat start at high speed with a tick every 4 clks, then drop into purge.
        tbl.push_back(mk(1, 0, 1, 0, 2'd2, 1, 1, 0, 0));
        for (int k = 1; k <= 17; k++) begin
            tbl.push_back(mk(4, 1, 1, 0, 2'd2, 1, 1, 0, (k * 16 > 255) ? 255 : k * 16));
        end
        tbl.push_back(mk(1, 0, 0, 0, 2'd2, 2, 0, 0, 255));
        tbl.push_back(mk(4, 1, 0, 0, 2'd2, 2, 0, 0, 239));
        tbl.push_back(mk(4, 1, 0, 0, 2'd2, 2, 0, 0, 223));
        tbl.push_back(mk(4, 1, 0, 0, 2'd2, 2, 0, 0, 207));
        tbl.push_back(mk(4, 1, 0, 0, 2'd2, 0, 0, 0, 191));
        tbl.push_back(mk(4, 1, 0, 0, 2'd2, 0, 0, 0, 175));

        // Reset state.
        step(0, 0, 0, 0, 2'd0);
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_duty",  32'(fan_duty), 32'd0);
        chk("reset_pwm",   32'(fan_pwm), 32'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            vec_t v;
            v = tbl[k];
            for (int i = 0; i < v.n_clk; i++) begin
                step(1, v.tck && (i == v.n_clk - 1), v.h, v.c, v.s);
            end
            chk($sformatf("tbl%0d_state", k),   32'(state_o),  32'(v.e_state));
            chk($sformatf("tbl%0d_heat_en", k), 32'(heat_en),  32'(v.e_heat));
            chk($sformatf("tbl%0d_cool_en", k), 32'(cool_en),  32'(v.e_cool));
            chk($sformatf("tbl%0d_duty", k),    32'(fan_duty), 32'(v.e_duty));
        end

        // Minimum on-time: request drops after 3 ticks, element holds for 10.
        step(0, 0, 0, 0, 2'd0);
        step(1, 0, 1, 0, 2'd2);
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 2'd2); ticks++;
            step(1, 0, 1, 0, 2'd2);
        end
        for (int i = 0; i < 200 && state_o == 2'd1; i++) begin
            t = (i % 2 == 0);
            step(1, t, 0, 0, 2'd2);
            if (t) ticks++;
        end
        chk("min_on_ticks", 32'(ticks), 32'(MON));
        chk("min_on_purge", 32'(state_o), 32'd2);
        ticks = 0;
        for (int i = 0; i < 200 && state_o == 2'd2; i++) begin
            t = (i % 2 == 0);
            step(1, t, 0, 0, 2'd2);
            if (t) ticks++;
        end
        chk("purge_ticks", 32'(ticks), 32'(PT));
        chk("purge_duty",  32'(fan_duty), 32'(DLOW));
        chk("purge_off",   32'(state_o), 32'd0);

        // Heat to cool switch must wait out the lockout from purge entry.
        step(0, 0, 0, 0, 2'd0);
        step(1, 0, 1, 0, 2'd2);
        for (int i = 0; i < MON + 2; i++) begin
            step(1, 1, 1, 0, 2'd2);
            step(1, 0, 1, 0, 2'd2);
        end
        step(1, 0, 0, 1, 2'd2);
        chk("switch_purge", 32'(state_o), 32'd2);
        ticks = 0;
        for (int i = 0; i < 200 && cool_en !== 1'b1; i++) begin
            t = (i % 2 == 0);
            step(1, t, 0, 1, 2'd2);
            if (t) ticks++;
        end
        chk("lockout_ticks", 32'(ticks), 32'(MOFF));
        chk("switch_cool_en", 32'(cool_en), 32'd1);
        chk("switch_heat_en", 32'(heat_en), 32'd0);

        // Conflicting requests from OFF.
        step(0, 0, 0, 0, 2'd0);
        for (int i = 0; i < 6; i++) step(1, (i % 2 == 0), 1, 1, 2'd2);
        chk("conflict_fault", 32'(fault), 32'd1);
        chk("conflict_state", 32'(state_o), 32'd0);
        chk("conflict_en",    32'({heat_en, cool_en}), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 2'd0);
        chk("fault_sticky", 32'(fault), 32'd1);

        // PWM duty 96 and duty 0 over a full period.
        step(0, 0, 0, 0, 2'd0);
        step(1, 0, 1, 0, 2'd1);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 0, 2'd1);
            step(1, 0, 1, 0, 2'd1);
        end
        chk("pwm96_duty", 32'(fan_duty), 32'(DLOW));
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 1, 0, 2'd1);
            if (fan_pwm === 1'b1) cnt++;
        end
        chk("pwm96_high", 32'(cnt), 32'(DLOW));
        step(0, 0, 0, 0, 2'd0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 0, 0, 2'd0);
            if (fan_pwm !== 1'b0) cnt++;
        end
        chk("pwm0_high", 32'(cnt), 32'd0);

        // Reset mid-run at full duty, with a fault already set.
        step(0, 0, 0, 0, 2'd0);
        step(1, 0, 1, 0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 2'd2);
            step(1, 0, 1, 0, 2'd2);
        end
        step(1, 0, 1, 1, 2'd2);
        chk("midrun_fault", 32'(fault), 32'd1);
        chk("midrun_state", 32'(state_o), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 1, 0, 2'd2);
            step(1, 0, 1, 0, 2'd2);
        end
        chk("midrun_duty", 32'(fan_duty), 32'd255);
        step(0, 0, 1, 0, 2'd2);
        chk("rst_heat_en", 32'(heat_en), 32'd0);
        chk("rst_fan_pwm", 32'(fan_pwm), 32'd0);
        chk("rst_duty",    32'(fan_duty), 32'd0);
        chk("rst_state",   32'(state_o), 32'd0);
        chk("rst_fault",   32'(fault), 32'd0);

        // Randomised stimulus against the model; requests held for stretches.
        step(0, 0, 0, 0, 2'd0);
        h = 0; c = 0; s = 2'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2:    begin h = 0; c = 0; end
                    3, 4, 5:    begin h = 1; c = 0; end
                    6, 7, 8:    begin h = 0; c = 1; end
                    default:    begin h = 1; c = 1; end
                endcase
                s = 2'($urandom_range(0, 3));
            end
            t = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1499) != 0);
            step(r, t, h, c, s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
